// File: rtl/nuart_pkg.sv
// Shared types and helpers for the nuart receiver family.
package nuart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WRITE
  } nuart_state_e;

  localparam int NUART_PAR_NONE = 0;
  localparam int NUART_PAR_EVEN = 1;
  localparam int NUART_PAR_ODD  = 2;

  // Expected parity bit given the XOR of the data bits.
  function automatic logic nuart_par_bit(input int mode, input logic dxor);
    return (mode == NUART_PAR_ODD) ? ~dxor : dxor;
  endfunction
endpackage

// File: rtl/nuart_rx_sync.sv
// Two-flop synchroniser with falling-edge detect; also used on the TX CTS input.
module nuart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d,
  output logic q,
  output logic fall
);
  logic [1:0] ff;
  logic       prev;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ff   <= 2'b11;
      prev <= 1'b1;
    end else begin
      ff   <= {ff[0], d};
      prev <= ff[1];
    end
  end

  assign q    = ff[1];
  assign fall = prev & ~ff[1];
endmodule

// File: rtl/nuart_rx_p.sv
// Parametrised UART receiver. Define NUART_RX_MAJORITY_EN for 2-of-3 majority
// sampling around each bit's decision point.
module nuart_rx_p
  import nuart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVS         = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 rxd_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_wr_o,
  output logic [DATA_BITS-1:0] fifo_data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int CW = $clog2(OVS);
  localparam int BW = 4;

  nuart_state_e         state, state_nx;
  logic                 rxd_s, fall, samp, rx_bit, in_wr;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh, data_q;
  logic                 perr, ferr, perr_q, ferr_q;

  nuart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d      (rxd_i),
    .q      (rxd_s),
    .fall   (fall)
  );

`ifdef NUART_RX_MAJORITY_EN
  // Decision at the nominal point uses it plus the two preceding tick samples.
  logic [1:0] hist;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    hist <= 2'b11;
    else if (tick_i) hist <= {hist[0], rxd_s};
  end
  assign rx_bit = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign rx_bit = rxd_s;
`endif

  assign samp = tick_i && (cnt == ((state == ST_START) ? CW'(OVS/2 - 1) : CW'(OVS - 1)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (fall) state_nx = ST_START;
      ST_START:  if (samp) state_nx = rx_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (samp && bcnt == BW'(DATA_BITS - 1))
                   state_nx = (PARITY_MODE != NUART_PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (samp) state_nx = ST_STOP;
      ST_STOP:   if (samp && bcnt == BW'(STOP_BITS - 1)) state_nx = ST_WRITE;
      ST_WRITE:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Tick and bit counters; the bit counter is reused for stop bits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt  <= '0;
      bcnt <= '0;
    end else begin
      if (state == ST_IDLE) cnt <= '0;
      else if (tick_i)      cnt <= samp ? '0 : cnt + 1'b1;
      if (state == ST_IDLE || state == ST_START) bcnt <= '0;
      else if (samp)
        bcnt <= ((state == ST_DATA && bcnt == BW'(DATA_BITS - 1)) || state == ST_PARITY)
                ? '0 : bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh     <= '0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && fall) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == ST_DATA && samp) sh <= {rx_bit, sh[DATA_BITS-1:1]};
      if (state == ST_PARITY && samp && rx_bit != nuart_par_bit(PARITY_MODE, ^sh))
        perr <= 1'b1;
      if (state == ST_STOP && samp && !rx_bit) ferr <= 1'b1;
      if (state == ST_WRITE && !fifo_full_i) begin
        data_q <= sh;
        perr_q <= perr;
        ferr_q <= ferr;
      end
    end
  end

  // Live frame values during WRITE, last written character otherwise.
  assign in_wr        = (state == ST_WRITE);
  assign fifo_wr_o    = in_wr && !fifo_full_i;
  assign overrun_o    = in_wr && fifo_full_i;
  assign busy_o       = (state != ST_IDLE);
  assign fifo_data_o  = in_wr ? sh   : data_q;
  assign parity_err_o = in_wr ? perr : perr_q;
  assign frame_err_o  = in_wr ? ferr : ferr_q;
endmodule
